// File: rtl/csa_add_sequencer_if.sv
// csa_add_sequencer_if: operand stream, adder link and result stream of the add sequencer
interface csa_add_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_first;
  logic             in_last;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_last;
  logic [IDXW-1:0]  out_idx;
  logic             out_ovf;
  logic             err;
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_first, in_last, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_last, out_idx, out_ovf, err
  );
  modport master (
    output in_valid, in_a, in_b, in_cin, in_first, in_last, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_last, out_idx, out_ovf, err
  );
endinterface

// File: rtl/csa_add_sequencer.sv
// csa_add_sequencer: feeds chained operand words to the carry-skip adder; CSA_SEQ_OVF_EN enables signed overflow on final words
module csa_add_sequencer #(
  parameter int WIDTH  = 32,
  parameter int NWORDS = 4,
  parameter int IDXW   = 2
) (
  input logic clk,
  input logic rst,
  csa_add_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic cin_q, cout_q, carry_q, last_q, out_last_q, err_q, started_q;
  logic [IDXW-1:0] cnt_q, idx_q, out_idx_q;
  logic accept, first_eff, last_eff;
  logic [IDXW-1:0] idx_w;
  assign accept    = bus.in_valid & (state_q == IDLE);
  assign first_eff = bus.in_first | ~started_q;
  assign idx_w     = first_eff ? '0 : cnt_q;
  assign last_eff  = bus.in_last | (idx_w == LAST_IDX);
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // Next state: accept in IDLE, one compute cycle, hold until downstream takes the result
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE && bus.in_valid) ? CALC :
              (state_q == CALC) ? HOLD :
              (state_q == HOLD && bus.out_ready) ? IDLE : state_q;
  end
  // Operand launch: registers adder inputs and chain bookkeeping on an accepted word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0; b_q <= '0; cin_q <= 1'b0; idx_q <= '0; last_q <= 1'b0;
      cnt_q <= '0; started_q <= 1'b0; err_q <= 1'b0;
    end else if (accept) begin
      a_q       <= bus.in_a;
      b_q       <= bus.in_b;
      cin_q     <= first_eff ? bus.in_cin : carry_q;
      idx_q     <= idx_w;
      last_q    <= last_eff;
      cnt_q     <= last_eff ? '0 : idx_w + IDXW'(1);
      started_q <= 1'b1;
      err_q     <= ((idx_w == LAST_IDX) & ~bus.in_last) | (err_q & ~bus.in_first);
    end
  // Result capture: sample the adder's combinational return in the compute cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sum_q <= '0; cout_q <= 1'b0; carry_q <= 1'b0; out_idx_q <= '0; out_last_q <= 1'b0;
    end else if (state_q == CALC) begin
      sum_q      <= bus.add_sum;
      cout_q     <= bus.add_cout;
      carry_q    <= bus.add_cout;
      out_idx_q  <= idx_q;
      out_last_q <= last_q;
    end
`ifdef CSA_SEQ_OVF_EN
  logic ovf_q;
  // Signed overflow of the most significant (final) word only
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf_q <= 1'b0;
    else if (state_q == CALC)
      ovf_q <= last_q & (a_q[WIDTH-1] == b_q[WIDTH-1]) & (bus.add_sum[WIDTH-1] != a_q[WIDTH-1]);
  assign bus.out_ovf = ovf_q;
`else
  assign bus.out_ovf = 1'b0;
`endif
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == HOLD;
  assign bus.add_a     = a_q;
  assign bus.add_b     = b_q;
  assign bus.add_cin   = cin_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_csa_add_sequencer.sv
// tb_csa_add_sequencer: table vectors, random chains against a word-level model, backpressure and reset cases
module tb_csa_add_sequencer;
  localparam int NWORDS = 4;
`ifdef CSA_SEQ_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif
  typedef struct {
    logic [31:0] sum;
    logic cout;
    logic [1:0] idx;
    logic last;
    logic ovf;
    logic err;
  } res_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic cin;
    logic first;
    logic last;
    res_t exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  bit m_carry, m_err, m_started;
  int m_cnt;
  vec_t tbl[10];
  csa_add_sequencer_if #(.WIDTH(32), .IDXW(2)) bus ();
  csa_add_sequencer #(.WIDTH(32), .NWORDS(NWORDS), .IDXW(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + 33'(bus.add_cin);
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic cmp(input string tag, input res_t g, input res_t e);
    chk({tag, ".sum"}, g.sum, e.sum);
    chk({tag, ".cout"}, g.cout, e.cout);
    chk({tag, ".idx"}, g.idx, e.idx);
    chk({tag, ".last"}, g.last, e.last);
    chk({tag, ".ovf"}, g.ovf, e.ovf);
    chk({tag, ".err"}, g.err, e.err);
  endtask

  function automatic res_t model(input logic [31:0] a, b, input logic cin, first, last);
    res_t r;
    bit fe = first || !m_started;
    int idx = fe ? 0 : m_cnt;
    logic [32:0] t = {1'b0, a} + {1'b0, b} + 33'(fe ? cin : m_carry);
    r.sum = t[31:0];
    r.cout = t[32];
    r.idx = 2'(idx);
    r.last = last || idx == NWORDS - 1;
    r.ovf = OVF_ON && r.last && a[31] == b[31] && t[31] != a[31];
    if (first) m_err = 1'b0;
    if (idx == NWORDS - 1 && !last) m_err = 1'b1;
    r.err = m_err;
    m_cnt = r.last ? 0 : idx + 1;
    m_carry = t[32];
    m_started = 1'b1;
    return r;
  endfunction

  task automatic do_word(input logic [31:0] a, b, input logic cin, first, last, input int hold, output res_t got);
    int n;
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_first = first; bus.in_last = last;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 8);
    chk("latency", n, 2);
    got = '{bus.out_sum, bus.out_cout, bus.out_idx, bus.out_last, bus.out_ovf, bus.err};
    chk("add_a", bus.add_a, a);
    chk("add_b", bus.add_b, b);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = (i == 2);
      bus.in_a = $urandom; bus.in_first = 1'b1;
      @(negedge clk);
      chk("hold_sum", bus.out_sum, got.sum);
      chk("hold_cout", bus.out_cout, got.cout);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("ready_after", bus.in_ready, 1);
    chk("valid_after", bus.out_valid, 0);
  endtask

  initial begin
    res_t g, e;
    tbl[0] = '{32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, '{32'h0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0}};
    tbl[1] = '{32'h0, 32'h0, 1'b0, 1'b0, 1'b1, '{32'h1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0}};
    tbl[2] = '{32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b1, '{32'h80000000, 1'b0, 2'd0, 1'b1, OVF_ON, 1'b0}};
    tbl[3] = '{32'h1, 32'h2, 1'b0, 1'b1, 1'b0, '{32'h3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0}};
    tbl[4] = '{32'h10, 32'h20, 1'b0, 1'b0, 1'b0, '{32'h30, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, '{32'hFFFFFFFE, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0}};
    tbl[6] = '{32'h0, 32'h0, 1'b0, 1'b0, 1'b0, '{32'h1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1}};
    tbl[7] = '{32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, '{32'h0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0}};
    tbl[8] = '{32'h5, 32'h3, 1'b1, 1'b1, 1'b0, '{32'h9, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0}};
    tbl[9] = '{32'h0, 32'h0, 1'b0, 1'b0, 1'b1, '{32'h0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0}};
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
    bus.in_first = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    m_carry = 1'b0; m_err = 1'b0; m_started = 1'b0; m_cnt = 0;
    #3;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_add_a", bus.add_a, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      e = model(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].first, tbl[i].last);
      do_word(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].first, tbl[i].last, (i == 0) ? 5 : 0, g);
      cmp($sformatf("vec%0d", i), g, tbl[i].exp);
    end
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = ($urandom_range(0, 3) == 0) ? ~a : $urandom;
      logic cin = 1'($urandom_range(0, 1));
      logic first = $urandom_range(0, 3) == 0;
      logic last = $urandom_range(0, 2) == 0;
      e = model(a, b, cin, first, last);
      do_word(a, b, cin, first, last, $urandom_range(0, 2), g);
      cmp($sformatf("rnd%0d", i), g, e);
    end
    bus.in_a = 32'hFFFFFFFF; bus.in_b = 32'h1; bus.in_cin = 1'b0;
    bus.in_first = 1'b1; bus.in_last = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_sum", bus.out_sum, 0);
    chk("arst_out_cout", bus.out_cout, 0);
    chk("arst_add_a", bus.add_a, 0);
    chk("arst_add_cin", bus.add_cin, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    m_carry = 1'b0; m_err = 1'b0; m_started = 1'b0; m_cnt = 0;
    @(negedge clk);
    e = model(32'h3, 32'h4, 1'b0, 1'b0, 1'b1);
    do_word(32'h3, 32'h4, 1'b0, 1'b0, 1'b1, 0, g);
    cmp("post_rst", g, e);
    chk("post_rst_sum_const", g.sum, 32'h7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
